// File: rtl/mem_line_xfer.sv
// Cache line transfer engine: optional writeback of a victim line, then a
// word-by-word fill of a new line over a single-cycle 16-bit memory port.
module mem_line_xfer #(
    parameter int WORDS = 4,
    parameter int CW    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  req_wb,
    input  logic [15:0]           fill_addr,
    input  logic [15:0]           wb_addr,
    input  logic [16*WORDS-1:0]   wb_data,
    output logic                  busy,
    output logic                  done,
    output logic [16*WORDS-1:0]   fill_data,
    output logic [15:0]           mem_addr,
    output logic [15:0]           mem_data_in,
    input  logic [15:0]           mem_data_out,
    output logic                  mem_enable,
    output logic                  mem_wr
);

    typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

    localparam logic [15:0] ALIGN_MASK = ~16'(2*WORDS-1);

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [15:0]           fillBase_q, fillBase_d;
    logic [15:0]           wbBase_q, wbBase_d;
    logic [16*WORDS-1:0]   wbLine_q, wbLine_d;
    logic [16*WORDS-1:0]   fillData_q, fillData_d;
    logic                  lastWord;
    logic [15:0]           wordOffset;

    assign lastWord   = (cnt_q == CW'(WORDS-1));
    assign wordOffset = 16'(cnt_q) << 1;
    assign fill_data  = fillData_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            fillBase_q <= '0;
            wbBase_q   <= '0;
            wbLine_q   <= '0;
            fillData_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fillBase_q <= fillBase_d;
            wbBase_q   <= wbBase_d;
            wbLine_q   <= wbLine_d;
            fillData_q <= fillData_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fillBase_d = fillBase_q;
        wbBase_d   = wbBase_q;
        wbLine_d   = wbLine_q;
        fillData_d = fillData_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    fillBase_d = fill_addr & ALIGN_MASK;
                    wbBase_d   = wb_addr & ALIGN_MASK;
                    wbLine_d   = wb_data;
                    cnt_d      = '0;
                    state_d    = req_wb ? WB : FILL;
                end
            end
            WB: begin
                cnt_d = cnt_q + 1'b1;
                if (lastWord) begin
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                // Only the word addressed this cycle is replaced; the rest hold.
                fillData_d[16*cnt_q +: 16] = mem_data_out;
                cnt_d = cnt_q + 1'b1;
                if (lastWord) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory strobes are gated by rst so an abort issues no further access.
    always_comb begin
        busy        = (state_q != IDLE);
        done        = (state_q == DONE);
        mem_enable  = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        case (state_q)
            WB: begin
                mem_enable  = !rst;
                mem_wr      = !rst;
                mem_addr    = wbBase_q + wordOffset;
                mem_data_in = wbLine_q[16*cnt_q +: 16];
            end
            FILL: begin
                mem_enable  = !rst;
                mem_addr    = fillBase_q + wordOffset;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_line_xfer.sv
// Self-checking bench for mem_line_xfer with a word-wide memory model and
// a scoreboard of expected memory accesses and fill lines.
module tb_mem_line_xfer;

    localparam int WORDS = 4;
    localparam int CW    = 2;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
    } acc_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 req;
    logic                 req_wb;
    logic [15:0]          fill_addr;
    logic [15:0]          wb_addr;
    logic [16*WORDS-1:0]  wb_data;
    logic                 busy;
    logic                 done;
    logic [16*WORDS-1:0]  fill_data;
    logic [15:0]          mem_addr;
    logic [15:0]          mem_data_in;
    logic [15:0]          mem_data_out;
    logic                 mem_enable;
    logic                 mem_wr;

    logic [15:0]          memWords [0:32767];
    acc_t                 accQ[$];
    logic [63:0]          fillQ[$];
    acc_t                 expAcc;
    logic [63:0]          expLine;
    int                   checks = 0;
    int                   errors = 0;

    always #5 clk = ~clk;

    mem_line_xfer #(.WORDS(WORDS), .CW(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_wb       (req_wb),
        .fill_addr    (fill_addr),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .busy         (busy),
        .done         (done),
        .fill_data    (fill_data),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_enable   (mem_enable),
        .mem_wr       (mem_wr)
    );

    // Memory stores one 16-bit word per even byte address, big-endian bytes.
    assign mem_data_out = memWords[mem_addr[15:1]];

    always @(posedge clk) begin
        if (mem_enable && mem_wr) memWords[mem_addr[15:1]] <= mem_data_in;
    end

    // Scoreboard monitor: every access and every done pulse must match the queue head.
    always @(negedge clk) begin
        if (mem_enable === 1'b1) begin
            checks++;
            if (accQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_access: got wr=%b addr=%h data=%h, required no access",
                         mem_wr, mem_addr, mem_data_in);
            end else begin
                expAcc = accQ.pop_front();
                if (mem_wr !== expAcc.wr || mem_addr !== expAcc.addr ||
                    (expAcc.wr && mem_data_in !== expAcc.data)) begin
                    errors++;
                    $display("[TB] FAIL access: got wr=%b addr=%h data=%h, required wr=%b addr=%h data=%h",
                             mem_wr, mem_addr, mem_data_in, expAcc.wr, expAcc.addr, expAcc.data);
                end
            end
        end
        if (done === 1'b1) begin
            checks++;
            if (fillQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_done: got done=1, required 0");
            end else begin
                expLine = fillQ.pop_front();
                if (fill_data !== expLine) begin
                    errors++;
                    $display("[TB] FAIL fill_data: got %h, required %h", fill_data, expLine);
                end
            end
        end
    end

    task automatic pushXfer(input logic wb, input logic [15:0] waddr, input logic [63:0] wdata,
                            input logic [15:0] faddr, input logic [63:0] expFill);
        logic [15:0] wBase;
        logic [15:0] fBase;
        wBase = waddr & 16'hFFF8;
        fBase = faddr & 16'hFFF8;
        if (wb) begin
            for (int i = 0; i < WORDS; i++)
                accQ.push_back('{1'b1, wBase + 16'(2*i), wdata[16*i +: 16]});
        end
        for (int i = 0; i < WORDS; i++)
            accQ.push_back('{1'b0, fBase + 16'(2*i), 16'h0000});
        fillQ.push_back(expFill);
    endtask

    task automatic runXfer(input logic wb, input logic [15:0] waddr, input logic [63:0] wdata,
                           input logic [15:0] faddr, input logic [63:0] expFill,
                           input int expLat, input bit holdReq, input string name);
        int lat;
        bit seen;
        pushXfer(wb, waddr, wdata, faddr, expFill);
        @(posedge clk); #1;
        req       = 1'b1;
        req_wb    = wb;
        fill_addr = faddr;
        wb_addr   = waddr;
        wb_data   = wdata;
        @(posedge clk); #1;
        if (!holdReq) req = 1'b0;
        req_wb    = ~wb;
        fill_addr = 16'($urandom);
        wb_addr   = 16'($urandom);
        wb_data   = {$urandom, $urandom};
        lat  = 0;
        seen = 0;
        while (lat < 40 && !seen) begin
            @(negedge clk);
            lat++;
            if (done === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL %s timeout: got no done within %0d cycles, required done in cycle %0d",
                     name, lat, expLat);
            accQ.delete();
            fillQ.delete();
        end else if (lat != expLat || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s latency: got done in cycle %0d busy=%b, required cycle %0d busy=1",
                     name, lat, busy, expLat);
        end
        checks++;
        if (accQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s missing_accesses: got %0d outstanding, required 0", name, accQ.size());
            accQ.delete();
        end
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || fill_data !== expFill) begin
            errors++;
            $display("[TB] FAIL %s after_done: got busy=%b done=%b fill=%h, required busy=0 done=0 fill=%h",
                     name, busy, done, fill_data, expFill);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || mem_enable !== 1'b0 || mem_wr !== 1'b0 ||
                mem_addr !== 16'h0 || mem_data_in !== 16'h0) begin
                errors++;
                $display("[TB] FAIL reset_idle: got busy=%b done=%b en=%b wr=%b addr=%h din=%h, required all 0",
                         busy, done, mem_enable, mem_wr, mem_addr, mem_data_in);
            end
            checks++;
            if (fill_data !== 64'h0) begin
                errors++;
                $display("[TB] FAIL reset_fill: got %h, required 0", fill_data);
            end
        end
    endtask

    task automatic test_fill_only();
        memWords[16'h0020] = 16'h1122;
        memWords[16'h0021] = 16'h3344;
        memWords[16'h0022] = 16'h5566;
        memWords[16'h0023] = 16'h7788;
        runXfer(1'b0, 16'h1234, 64'h0, 16'h0045, 64'h7788_5566_3344_1122, 5, 1'b0, "fill_only");
    endtask

    task automatic test_writeback();
        logic [15:0] expW [0:3];
        expW[0] = 16'hAAAA; expW[1] = 16'hBBBB; expW[2] = 16'hCCCC; expW[3] = 16'hDDDD;
        runXfer(1'b1, 16'h0100, 64'hDDDD_CCCC_BBBB_AAAA, 16'h0040, 64'h7788_5566_3344_1122,
                9, 1'b0, "writeback");
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (memWords[16'h0080 + 16'(i)] !== expW[i]) begin
                errors++;
                $display("[TB] FAIL wb_dump[%0d]: got %h, required %h", i, memWords[16'h0080 + 16'(i)], expW[i]);
            end
        end
    endtask

    task automatic test_same_line();
        runXfer(1'b1, 16'h0200, 64'h0004_0003_0002_0001, 16'h0200, 64'h0004_0003_0002_0001,
                9, 1'b0, "same_line");
    endtask

    task automatic test_wrap();
        memWords[16'h7FFC] = 16'hA1A1;
        memWords[16'h7FFD] = 16'hB2B2;
        memWords[16'h7FFE] = 16'hC3C3;
        memWords[16'h7FFF] = 16'hD4D4;
        runXfer(1'b0, 16'h0000, 64'h0, 16'hFFFF, 64'hD4D4_C3C3_B2B2_A1A1, 5, 1'b0, "wrap");
    endtask

    task automatic test_reset_mid();
        pushXfer(1'b1, 16'h0400, 64'h4444_3333_2222_1111, 16'h0040, 64'h0);
        @(posedge clk); #1;
        req     = 1'b1;
        req_wb  = 1'b1;
        wb_addr = 16'h0400;
        wb_data = 64'h4444_3333_2222_1111;
        fill_addr = 16'h0040;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_enable !== 1'b0 || mem_wr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_strobe: got en=%b wr=%b, required 0 0", mem_enable, mem_wr);
        end
        checks++;
        if (accQ.size() != 2*WORDS - 2) begin
            errors++;
            $display("[TB] FAIL reset_mid_count: got %0d outstanding, required %0d", accQ.size(), 2*WORDS - 2);
        end
        accQ.delete();
        fillQ.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_idle: got busy=%b, required 0", busy);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_mid_quiet: got done=%b busy=%b, required 0 0", done, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        runXfer(1'b1, 16'h0300, 64'h9999_8888_7777_6666, 16'h0040, 64'h7788_5566_3344_1122,
                9, 1'b1, "hold_req");
        runXfer(1'b0, 16'h0000, 64'h0, 16'h0302, 64'h9999_8888_7777_6666, 5, 1'b1, "hold_req_fill");
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) memWords[i] = 16'h0000;
        rst       = 1'b1;
        req       = 1'b0;
        req_wb    = 1'b0;
        fill_addr = 16'h0;
        wb_addr   = 16'h0;
        wb_data   = '0;
        test_reset();
        test_fill_only();
        test_writeback();
        test_same_line();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_line_xfer.md
Name: mem_line_xfer

Overview:
- Initiator-side line transfer engine for the cache subsystem.
- On a cache miss it drives the single-cycle, byte-addressable, 16-bit memory interface.
- It first writes back an optional dirty line of WORDS 16-bit words, then fills a new line of WORDS words.
- It returns the assembled fill line to the cache controller with a one-cycle done pulse.

Parameters:
- WORDS, 4, words per cache line. Power of two, 2..8. Line size in bytes is 2*WORDS.
- CW, 2, word-counter width. Must equal log2(WORDS).

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  1  start request; sampled only in IDLE
- req_wb  input  1  writeback of wb_data required before fill; sampled with req
- fill_addr  input  16  byte address of line to fill; low log2(2*WORDS) bits ignored
- wb_addr  input  16  byte address of victim line; low log2(2*WORDS) bits ignored
- wb_data  input  16*WORDS  victim line; word i in bits [16i+15:16i]
- busy  output  1  engine not in IDLE
- done  output  1  one-cycle pulse when transfer complete
- fill_data  output  16*WORDS  filled line; word i in bits [16i+15:16i]
- mem_addr  output  16  memory byte address
- mem_data_in  output  16  write data to memory
- mem_data_out  input  16  read data from memory (combinational, zero latency)
- mem_enable  output  1  memory access strobe
- mem_wr  output  1  1 = write, 0 = read

Behaviour:
- Reset: the synchronous reset is `rst`, a single active-high input sampled on the rising edge of `clk`. On that edge:
  - state to IDLE, word counter to 0
  - fill_data, latched addresses and latched wb line to 0
  - busy, done, mem_enable, mem_wr to 0; mem_addr and mem_data_in to 0
- While rst is high, mem_enable and mem_wr are forced 0 combinationally. Reset mid-transfer aborts with no further memory accesses, and no done pulse is issued.
- States: IDLE, WB, FILL, DONE. Outputs are decoded from registered state; no output depends combinationally on req.
- IDLE: on an edge with req=1, latch the line-aligned fill_addr, the line-aligned wb_addr and wb_data; clear the counter. Next state is WB if req_wb=1, else FILL. req=0 stays in IDLE.
- WB: mem_enable=1, mem_wr=1, mem_addr = wb_base + 2*cnt, mem_data_in = latched word cnt.
  - The memory commits the write on the edge.
  - cnt increments each cycle; at cnt=WORDS-1, cnt returns to 0 and next state is FILL.
- FILL: mem_enable=1, mem_wr=0, mem_addr = fill_base + 2*cnt.
  - On the edge, mem_data_out is captured into fill_data word cnt; other words hold.
  - At cnt=WORDS-1, next state is DONE.
- DONE: done=1 for exactly one cycle; mem_enable=0; next state is IDLE.
- busy=1 in WB, FILL and DONE.
- Latency from the req edge:
  - req_wb=1: WB cycles 1..WORDS, FILL cycles WORDS+1..2*WORDS, done in cycle 2*WORDS+1.
  - req_wb=0: FILL cycles 1..WORDS, done in cycle WORDS+1.
- Only one memory access is issued per cycle. Read and write are never concurrent.
- req while busy is ignored, not queued. req may be asserted in the DONE cycle but is not accepted until IDLE.
- fill_data holds its value from DONE until the next FILL overwrites it word by word. The cache must copy it by DONE.
- Address arithmetic is 16-bit. Aligned bases never carry out (last word of base 0xFFF8 is 0xFFFE).
- wb_addr equal to fill_addr is legal: the writeback completes before the first read, so the fill returns the written data.
- wb_data and address inputs may change freely after the accepting edge.
- Outside WB/FILL, mem_addr and mem_data_in are 0.

Test Plan:
- Reset, then idle 5 cycles -> busy=0, done=0, mem_enable=0, fill_data=0; no memory accesses.
- Preload memory 0x0040..0x0047 = 11 22 33 44 55 66 77 88; req=1, req_wb=0, fill_addr=0x0045 -> reads at 0x0040/42/44/46 in cycles 1-4; done in cycle 5; fill_data=0x7788_5566_3344_1122.
- req=1, req_wb=1, wb_addr=0x0100, wb_data=0xDDDD_CCCC_BBBB_AAAA, fill_addr=0x0040 -> writes 0xAAAA@0x100, 0xBBBB@0x102, 0xCCCC@0x104, 0xDDDD@0x106 in cycles 1-4; reads cycles 5-8; done cycle 9; memory dump confirms the writes.
- Same-line writeback then fill: wb_addr=fill_addr=0x0200, wb_data=0x0004_0003_0002_0001 -> fill_data=0x0004_0003_0002_0001.
- Wrap boundary: fill_addr=0xFFFF -> addresses 0xFFF8, 0xFFFA, 0xFFFC, 0xFFFE; done after 4 accesses.
- Pulse rst in cycle 3 of a WB transfer -> mem_enable=0 that cycle; state IDLE next; no done. A fresh req completes normally. req held high during busy produces exactly one transfer per acceptance.
